// File: rtl/defines_pkg.sv
// rtl/defines_pkg.sv - shared types and constants for the SPU load/store pipe
package defines_pkg;

  // Quadword load/store opcodes handled by the odd-pipe LS unit.
  typedef enum logic [2:0] {
    LQD  = 3'd0,
    LQX  = 3'd1,
    LQA  = 3'd2,
    STQD = 3'd3,
    STQX = 3'd4,
    STQA = 3'd5
  } ls_op_t;

  localparam int unsigned LS_SIZE_DEFAULT    = 32768;
  localparam int unsigned LS_LATENCY_DEFAULT = 6;

  // Local store limit register: byte mask for a power-of-two local store.
  function automatic logic [31:0] lslr(input int unsigned size);
    return 32'(size - 1);
  endfunction

  localparam logic [31:0] LSLR = lslr(LS_SIZE_DEFAULT);

  function automatic logic is_store(input ls_op_t op);
    return op inside {STQD, STQX, STQA};
  endfunction

  function automatic logic is_load(input ls_op_t op);
    return op inside {LQD, LQX, LQA};
  endfunction

endpackage

// File: rtl/ls_delay_pipe.sv
// rtl/ls_delay_pipe.sv - fixed-depth shift register carrying load results to writeback
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             clears every valid bit in the pipe
//   in_valid/rt/data  load result captured from the local store
//   out_valid/rt/data oldest entry; DEPTH == 0 makes the pipe a wire
module ls_delay_pipe #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RT_W   = 7,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [0:RT_W-1]   in_rt,
  input  logic [0:DATA_W-1] in_data,
  output logic              out_valid,
  output logic [0:RT_W-1]   out_rt,
  output logic [0:DATA_W-1] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_rt    = in_rt;
      assign out_data  = in_data;

      logic unused_ok;
      assign unused_ok = ^{clk, rst, flush};
    end else begin : g_shift
      logic              valid_q [DEPTH];
      logic [0:RT_W-1]   rt_q    [DEPTH];
      logic [0:DATA_W-1] data_q  [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            rt_q[i]    <= '0;
            data_q[i]  <= '0;
          end
        end else begin
          valid_q[0] <= in_valid & ~flush;
          rt_q[0]    <= in_rt;
          data_q[0]  <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1] & ~flush;
            rt_q[i]    <= rt_q[i-1];
            data_q[i]  <= data_q[i-1];
          end
        end
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_rt    = rt_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/spu_ls_pipe.sv
// rtl/spu_ls_pipe.sv - SPU odd-pipe quadword load/store address and data pipe
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   op_valid, op_code        issued load/store operation
//   ra_data, rb_data, imm    address operands (preferred slot = bits 0:31)
//   rt_data, rt_addr         store data / load destination register
//   flush                    kill every in-flight operation
//   ls_addr, ls_data_wr,
//   ls_wr_en, ls_data_rd     local store port (quadword index)
//   wb_valid, wb_rt_addr,
//   wb_data                  load writeback, LS_LATENCY cycles after issue
module spu_ls_pipe
  import defines_pkg::*;
#(
  parameter int unsigned LS_SIZE    = LS_SIZE_DEFAULT,
  parameter int unsigned LS_LATENCY = LS_LATENCY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  ls_op_t       op_code,
  input  logic [0:127] ra_data,
  input  logic [0:127] rb_data,
  input  logic [0:127] rt_data,
  input  logic [0:15]  imm,
  input  logic [0:6]   rt_addr,
  input  logic         flush,
  output logic [0:31]  ls_addr,
  output logic [0:127] ls_data_wr,
  output logic         ls_wr_en,
  input  logic [0:127] ls_data_rd,
  output logic         wb_valid,
  output logic [0:6]   wb_rt_addr,
  output logic [0:127] wb_data
);

  // Byte mask that both wraps into the local store and aligns to a quadword.
  localparam logic [31:0] EA_MASK = lslr(LS_SIZE) & ~32'hF;

  logic [31:0]  ra_slot;
  logic [31:0]  rb_slot;
  logic [31:0]  imm_sext;
  logic [31:0]  byte_addr;
  logic [31:0]  eff_addr;
  logic         accept;

  logic [0:31]  ls_addr_d, ls_addr_q;
  logic [0:127] ls_data_wr_d, ls_data_wr_q;
  logic         ls_wr_en_d, ls_wr_en_q;
  logic         ld_valid_d, ld_valid_q;
  logic [0:6]   ld_rt_d, ld_rt_q;

  logic         pipe_valid;
  logic [0:6]   pipe_rt;
  logic [0:127] pipe_data;

  logic         wb_valid_d, wb_valid_q;
  logic [0:6]   wb_rt_d, wb_rt_q;
  logic [0:127] wb_data_d, wb_data_q;

  // Address generation: all arithmetic is modulo 2^32 on preferred slots.
  always_comb begin
    ra_slot  = ra_data[0:31];
    rb_slot  = rb_data[0:31];
    imm_sext = {{16{imm[0]}}, imm};
    case (op_code)
      LQD, STQD: byte_addr = ra_slot + (imm_sext << 4);
      LQX, STQX: byte_addr = ra_slot + rb_slot;
      LQA, STQA: byte_addr = imm_sext << 2;
      default:   byte_addr = '0;
    endcase
    eff_addr = byte_addr & EA_MASK;
  end

  // A flush in the issue cycle kills the op being presented as well.
  assign accept = op_valid & ~flush;

  always_comb begin
    ls_wr_en_d   = accept & is_store(op_code);
    ls_data_wr_d = ls_wr_en_d ? rt_data : '0;
    ld_valid_d   = accept & is_load(op_code);
    ld_rt_d      = ld_valid_d ? rt_addr : '0;
    // The LS address holds its last value while the stage is idle.
    ls_addr_d    = accept ? {4'b0, eff_addr[31:4]} : ls_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_addr_q    <= '0;
      ls_data_wr_q <= '0;
      ls_wr_en_q   <= 1'b0;
      ld_valid_q   <= 1'b0;
      ld_rt_q      <= '0;
    end else begin
      ls_addr_q    <= ls_addr_d;
      ls_data_wr_q <= ls_data_wr_d;
      ls_wr_en_q   <= ls_wr_en_d;
      ld_valid_q   <= ld_valid_d;
      ld_rt_q      <= ld_rt_d;
    end
  end

  // The store sitting in the LS stage during a flush still commits; only
  // the load valid bits downstream of it are dropped.
  assign ls_addr    = ls_addr_q;
  assign ls_data_wr = ls_data_wr_q;
  assign ls_wr_en   = ls_wr_en_q;

  ls_delay_pipe #(
    .DEPTH  (LS_LATENCY - 2),
    .RT_W   (7),
    .DATA_W (128)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (ld_valid_q),
    .in_rt     (ld_rt_q),
    .in_data   (ls_data_rd),
    .out_valid (pipe_valid),
    .out_rt    (pipe_rt),
    .out_data  (pipe_data)
  );

  // Gating here as well covers the zero-depth pipe, where the LS stage
  // feeds the writeback register directly.
  always_comb begin
    wb_valid_d = pipe_valid & ~flush;
    wb_rt_d    = wb_valid_d ? pipe_rt : '0;
    wb_data_d  = wb_valid_d ? pipe_data : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rt_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rt_q    <= wb_rt_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_rt_addr = wb_rt_q;
  assign wb_data    = wb_data_q;

  logic unused_ok;
  assign unused_ok = ^{ra_data[32:127], rb_data[32:127], eff_addr[3:0]};

endmodule
